// File: rtl/single_read_single_write_reg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// single_read_single_write_reg
//
// Purpose:
//   A single width-bit storage register with one write port and one read port.
//   A write lands on the rising edge of clk when write_enable is high, and the
//   stored word appears on read_data right after that edge. Reset is
//   asynchronous and active-high. It loads RESET_VALUE immediately and takes
//   priority over any write.
//
// Parameters:
//   width       - data width in bits (1 or more), default 16
//   RESET_VALUE - value loaded into the register by reset, default 0
//
// Ports (positional order):
//   write_data   [width-1:0] in  - word to be stored
//   clk                      in  - clock, rising edge active
//   reset                    in  - asynchronous active-high reset
//   write_enable             in  - store write_data on the next rising edge
//   read_data    [width-1:0] out - current stored word
//
// Optional feature (macro WRITE_BYPASS_EN):
//   When this macro is defined, read_data shows write_data combinationally
//   while write_enable=1 and reset=0. This gives an early look at the word
//   about to be written. In the default build the macro is not defined, and
//   read_data is always the flop output with no path from the inputs.
//   Register update behaviour is the same in both builds.
// ---------------------------------------------------------------------------
module single_read_single_write_reg #(
  parameter int               width       = 16,
  parameter logic [width-1:0] RESET_VALUE = '0
) (
  input  logic [width-1:0] write_data,
  input  logic             clk,
  input  logic             reset,
  input  logic             write_enable,
  output logic [width-1:0] read_data
);

  logic [width-1:0] data_q;
  logic [width-1:0] data_d;

  // Next-state selection: take the whole incoming word when a write is
  // requested, otherwise recirculate the stored word so the register holds.
  always_comb begin
    data_d = data_q;
    if (write_enable) begin
      data_d = write_data;
    end
  end

  // Storage flop. Reset is in the sensitivity list so that it takes effect
  // at once without waiting for a clock edge. Any write at an edge where
  // reset is high is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

`ifdef WRITE_BYPASS_EN
  // Bypass build: forward the pending write word to the read port.
  // The reset term keeps read_data at RESET_VALUE while reset is held,
  // even if a write is being requested at the same time.
  assign read_data = (write_enable && !reset) ? write_data : data_q;
`else
  // Default build: read port comes straight from the flop.
  assign read_data = data_q;
`endif

endmodule

// File: tb/tb_single_read_single_write_reg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_single_read_single_write_reg
//
// Purpose:
//   Directed testbench for single_read_single_write_reg with width=16 and
//   RESET_VALUE=0. The clock has period 10 and starts high. Inputs change
//   in the middle of the low phase. Outputs are sampled 1ns after each
//   rising edge.
//
//   If WRITE_BYPASS_EN is defined for the build, the checks made before
//   each edge expect read_data to show the forwarded word. Otherwise they
//   expect the old register value.
// ---------------------------------------------------------------------------
module tb_single_read_single_write_reg;

  localparam int W = 16;

  logic [W-1:0] write_data;
  logic         clk;
  logic         reset;
  logic         write_enable;
  logic [W-1:0] read_data;

  int checks;
  int errors;

  single_read_single_write_reg #(
    .width       (W),
    .RESET_VALUE ('0)
  ) dut (
    .write_data   (write_data),
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .read_data    (read_data)
  );

  // Clock: starts high, period 10, so rising edges fall at 10, 20, 30, ...
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Drive inputs in the middle of the low phase, well away from the next
  // rising edge.
  task automatic applyStimulus(input logic we, input logic [W-1:0] wd);
    @(negedge clk);
    #2;
    write_enable = we;
    write_data   = wd;
  endtask

  // Advance through the next rising edge and settle just after it.
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // Reset alone must force RESET_VALUE before any clock edge has occurred.
  task automatic test_reset();
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (read_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_immediate: read_data=%h expected=%h", read_data, 16'h0000);
    end
    // Release reset mid-low before the first rising edge at t=10.
    #5;
    reset = 1'b0;
    #1;
    checks++;
    if (read_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_release: read_data=%h expected=%h", read_data, 16'h0000);
    end
  endtask

  // A basic write lands after one edge, and is bypassed before it if enabled.
  task automatic test_write();
    logic [W-1:0] pre;
    applyStimulus(1'b1, 16'd25);
    #1;
`ifdef WRITE_BYPASS_EN
    pre = 16'd25;
`else
    pre = 16'd0;
`endif
    checks++;
    if (read_data !== pre) begin
      errors++;
      $display("[TB] FAIL write_pre_edge: read_data=%h expected=%h", read_data, pre);
    end
    stepEdge();
    checks++;
    if (read_data !== 16'd25) begin
      errors++;
      $display("[TB] FAIL write_25: read_data=%h expected=%h", read_data, 16'd25);
    end
  endtask

  // With write_enable low the register holds, and write_data is ignored.
  task automatic test_hold();
    applyStimulus(1'b0, 16'd50);
    #1;
    checks++;
    if (read_data !== 16'd25) begin
      errors++;
      $display("[TB] FAIL hold_pre_edge: read_data=%h expected=%h", read_data, 16'd25);
    end
    stepEdge();
    checks++;
    if (read_data !== 16'd25) begin
      errors++;
      $display("[TB] FAIL hold_25: read_data=%h expected=%h", read_data, 16'd25);
    end
  endtask

  // Reset asserted between edges clears at once and beats a concurrent write.
  task automatic test_reset_priority();
    applyStimulus(1'b1, 16'd75);
    stepEdge();
    checks++;
    if (read_data !== 16'd75) begin
      errors++;
      $display("[TB] FAIL write_75: read_data=%h expected=%h", read_data, 16'd75);
    end
    // Assert reset mid-low with a write request pending.
    applyStimulus(1'b1, 16'd99);
    reset = 1'b1;
    #1;
    checks++;
    if (read_data !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_async_mid: read_data=%h expected=%h", read_data, 16'd0);
    end
    stepEdge();
    stepEdge();
    checks++;
    if (read_data !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_blocks_write: read_data=%h expected=%h", read_data, 16'd0);
    end
    // Drop reset with no write pending. The register must stay at RESET_VALUE.
    applyStimulus(1'b0, 16'd99);
    reset = 1'b0;
    stepEdge();
    checks++;
    if (read_data !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_exit_hold: read_data=%h expected=%h", read_data, 16'd0);
    end
    // Normal writes resume on the first edge after reset has fallen.
    applyStimulus(1'b1, 16'd99);
    stepEdge();
    checks++;
    if (read_data !== 16'd99) begin
      errors++;
      $display("[TB] FAIL resume_write_99: read_data=%h expected=%h", read_data, 16'd99);
    end
  endtask

  // All ones, then all zeros, then alternating patterns on back-to-back
  // edges, so that every bit toggles in both directions.
  task automatic test_back_to_back();
    logic [W-1:0] pats [4];
    logic [W-1:0] prev;
    logic [W-1:0] pre;
    pats[0] = 16'hFFFF;
    pats[1] = 16'h0000;
    pats[2] = 16'hAAAA;
    pats[3] = 16'h5555;
    prev = 16'd99;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, pats[i]);
      #1;
`ifdef WRITE_BYPASS_EN
      pre = pats[i];
`else
      pre = prev;
`endif
      checks++;
      if (read_data !== pre) begin
        errors++;
        $display("[TB] FAIL toggle_pre_edge[%0d]: read_data=%h expected=%h", i, read_data, pre);
      end
      stepEdge();
      checks++;
      if (read_data !== pats[i]) begin
        errors++;
        $display("[TB] FAIL toggle_write[%0d]: read_data=%h expected=%h", i, read_data, pats[i]);
      end
      prev = pats[i];
    end
  endtask

  // Changes made between edges have no effect once they are withdrawn
  // before the next rising edge.
  task automatic test_between_edges();
    logic [W-1:0] mid;
    applyStimulus(1'b1, 16'h1234);
    stepEdge();
    checks++;
    if (read_data !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL between_setup: read_data=%h expected=%h", read_data, 16'h1234);
    end
    // Raise a write in the high phase, then withdraw it before the next edge.
    #1;
    write_enable = 1'b1;
    write_data   = 16'hBEEF;
    #1;
`ifdef WRITE_BYPASS_EN
    mid = 16'hBEEF;
`else
    mid = 16'h1234;
`endif
    checks++;
    if (read_data !== mid) begin
      errors++;
      $display("[TB] FAIL between_mid_cycle: read_data=%h expected=%h", read_data, mid);
    end
    applyStimulus(1'b0, 16'hBEEF);
    stepEdge();
    checks++;
    if (read_data !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL between_edges_ignored: read_data=%h expected=%h", read_data, 16'h1234);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    write_enable = 1'b0;
    write_data   = '0;
    $display("[TB] starting single_read_single_write_reg bench");
    test_reset();
    test_write();
    test_hold();
    test_reset_priority();
    test_back_to_back();
    test_between_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
